// File: rtl/serial_word_loader_if.sv
// Bundle of the serial-side handshake and the parallel word outputs of serial_word_loader.
// The master drives the serial stream and hold; the slave (the loader) answers.
interface serial_word_loader_if #(
    parameter int MSB   = 5,
    parameter int CNT_W = 8
);
    logic             ser_in;
    logic             ser_valid;
    logic             ser_sof;
    logic             ser_ready;
    logic             hold;
    logic [MSB-1:0]   out;
    logic             load;
    logic             err;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output ser_in, ser_valid, ser_sof, hold,
        input  ser_ready, out, load, err, word_cnt
    );

    modport slave (
        input  ser_in, ser_valid, ser_sof, hold,
        output ser_ready, out, load, err, word_cnt
    );
endinterface

// File: rtl/serial_word_loader.sv
// Assembles an LSB-first, sof-framed bit-serial stream into an MSB-bit word and
// presents it to the reverser with a one-cycle load strobe, honouring downstream hold.
module serial_word_loader #(
    parameter int MSB   = 5,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_word_loader_if.slave bus
);
    localparam int CW = $clog2(MSB + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [MSB-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [MSB-1:0]   out_q, out_d;
    logic             load_q, load_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             ready;
    logic             beat;

    function automatic logic [MSB-1:0] put_bit(input logic [MSB-1:0] w,
                                               input logic [CW-1:0]  pos,
                                               input logic           b);
        logic [MSB-1:0] m;
        m = MSB'(1) << pos;
        return b ? (w | m) : (w & ~m);
    endfunction

    // The only cycle the loader refuses bits is while a finished word waits to go out.
    assign ready = (state_q != PRESENT);
    assign beat  = bus.ser_valid && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            load_q  <= load_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        wcnt_d  = wcnt_q;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (bus.ser_sof) begin
                        shreg_d = MSB'(bus.ser_in);
                        cnt_d   = CW'(1);
                        state_d = (MSB == 1) ? PRESENT : SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (bus.ser_sof) begin
                        // Restart clears the stale upper bits so a later word never inherits them.
                        err_d   = 1'b1;
                        shreg_d = MSB'(bus.ser_in);
                        cnt_d   = CW'(1);
                        state_d = (MSB == 1) ? PRESENT : SHIFT;
                    end else begin
                        shreg_d = put_bit(shreg_q, cnt_q, bus.ser_in);
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == CW'(MSB - 1)) begin
                            state_d = PRESENT;
                        end
                    end
                end
            end
            PRESENT: begin
                if (!bus.hold) begin
                    out_d   = shreg_q;
                    load_d  = 1'b1;
                    wcnt_d  = wcnt_q + CNT_W'(1);
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.ser_ready = ready;
    assign bus.out       = out_q;
    assign bus.load      = load_q;
    assign bus.err       = err_q;
    assign bus.word_cnt  = wcnt_q;
endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: queue-based word model checked every cycle,
// directed framing/hold/reset scenarios with literal expectations, and random traffic.
module tb_serial_word_loader;
    localparam int MSB   = 5;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_word_loader_if #(.MSB(MSB), .CNT_W(CNT_W)) ifc ();

    serial_word_loader #(.MSB(MSB), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int err_seen   = 0;
    int load_seen  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bits of the current word in a queue; a full word waits in pend_word.
    bit             cur[$];
    bit             pending   = 1'b0;
    logic [MSB-1:0] pend_word = '0;
    logic [MSB-1:0] m_out     = '0;
    bit             m_load    = 1'b0;
    bit             m_err     = 1'b0;
    int             m_cnt     = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur.delete();
            pending   = 1'b0;
            pend_word = '0;
            m_out     = '0;
            m_load    = 1'b0;
            m_err     = 1'b0;
            m_cnt     = 0;
        end else begin
            m_load = 1'b0;
            m_err  = 1'b0;
            if (pending) begin
                if (!ifc.hold) begin
                    m_out   = pend_word;
                    m_load  = 1'b1;
                    m_cnt   = (m_cnt + 1) % (1 << CNT_W);
                    pending = 1'b0;
                end
            end else if (ifc.ser_valid) begin
                if (ifc.ser_sof) begin
                    if (cur.size() != 0) m_err = 1'b1;
                    cur.delete();
                    cur.push_back(ifc.ser_in);
                end else if (cur.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    cur.push_back(ifc.ser_in);
                end
                if (cur.size() == MSB) begin
                    pend_word = '0;
                    foreach (cur[i]) pend_word[i] = cur[i];
                    pending = 1'b1;
                    cur.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ser_ready", ifc.ser_ready, !pending);
        chk("load",      ifc.load,      m_load);
        chk("err",       ifc.err,       m_err);
        chk("out",       ifc.out,       m_out);
        chk("word_cnt",  ifc.word_cnt,  m_cnt);
        if (ifc.err === 1'b1)  err_seen++;
        if (ifc.load === 1'b1) load_seen++;
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        ifc.ser_valid = 1'b0;
        ifc.ser_sof   = 1'b0;
        ifc.ser_in    = 1'b0;
        ifc.hold      = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic beat(input logic b, input logic s, input int gap);
        int n;
        n = 0;
        ifc.ser_valid = 1'b1;
        ifc.ser_in    = b;
        ifc.ser_sof   = s;
        while (ifc.ser_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("beat_timeout", 1, 0);
        @(negedge clk);
        ifc.ser_valid = 1'b0;
        ifc.ser_sof   = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [MSB-1:0] w, input int maxgap);
        int g;
        for (int i = 0; i < MSB; i++) begin
            g = (i == MSB - 1) ? 0 : int'($urandom_range(0, maxgap));
            beat(w[i], (i == 0), g);
        end
    endtask

    task automatic wait_load(output int lat, output logic [MSB-1:0] w);
        lat = 0;
        while (ifc.load !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) chk("load_timeout", 1, 0);
        w = ifc.out;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        int             lat;
        int             e0;
        int             l0;
        logic [MSB-1:0] w;
        logic [MSB-1:0] word;

        ifc.ser_valid = 1'b0;
        ifc.ser_sof   = 1'b0;
        ifc.ser_in    = 1'b0;
        ifc.hold      = 1'b0;
        @(negedge clk);
        chk("rst_out", ifc.out, 0);
        chk("rst_ready", ifc.ser_ready, 1);
        chk("rst_cnt", ifc.word_cnt, 0);

        // Back-to-back word 1,0,0,1,1 with no hold
        do_reset();
        beat(1, 1, 0); beat(0, 0, 0); beat(0, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
        chk("t1_ready_low", ifc.ser_ready, 0);
        wait_load(lat, w);
        chk("t1_latency", lat, 1);
        chk("t1_out", w, 5'b11001);
        chk("t1_cnt", ifc.word_cnt, 1);
        chk("t1_ready_back", ifc.ser_ready, 1);
        @(negedge clk);
        chk("t1_load_drop", ifc.load, 0);

        // Same word stalled by hold for four cycles
        do_reset();
        beat(1, 1, 0); beat(0, 0, 0); beat(0, 0, 0); beat(1, 0, 0);
        ifc.hold = 1'b1;
        beat(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_ready_held", ifc.ser_ready, 0);
            chk("t2_no_load", ifc.load, 0);
            chk("t2_out_kept", ifc.out, 0);
            if (i < 3) @(negedge clk);
        end
        ifc.hold = 1'b0;
        wait_load(lat, w);
        chk("t2_latency", lat, 1);
        chk("t2_out", w, 5'b11001);
        chk("t2_cnt", ifc.word_cnt, 1);

        // Abandoned partial word restarted by a new sof
        do_reset();
        e0 = err_seen;
        beat(1, 1, 0); beat(1, 0, 0); beat(0, 0, 0);
        beat(0, 1, 0); beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
        wait_load(lat, w);
        chk("t3_err_count", err_seen - e0, 1);
        chk("t3_out", w, 5'b11110);
        chk("t3_cnt", ifc.word_cnt, 1);

        // Stray bit in IDLE, then a clean word
        do_reset();
        e0 = err_seen;
        beat(1, 0, 1);
        beat(0, 1, 0); beat(0, 0, 0); beat(0, 0, 0); beat(0, 0, 0); beat(1, 0, 0);
        wait_load(lat, w);
        chk("t4_err_count", err_seen - e0, 1);
        chk("t4_out", w, 5'b10000);

        // Reset in the middle of a word
        do_reset();
        beat(1, 1, 0); beat(0, 0, 0); beat(1, 0, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_out", ifc.out, 0);
        chk("t5_rst_ready", ifc.ser_ready, 1);
        #2 rst = 1'b1;
        @(negedge clk);
        l0 = load_seen;
        beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
        chk("t5_no_early_load", load_seen - l0, 0);
        chk("t5_out_before", ifc.out, 0);
        wait_load(lat, w);
        chk("t5_out", w, 5'b11111);
        chk("t5_cnt", ifc.word_cnt, 1);

        // 256 random words with gaps and random hold: counter wraps to zero
        do_reset();
        for (int k = 0; k < 256; k++) begin
            word     = MSB'($urandom);
            ifc.hold = $urandom_range(0, 1) == 1;
            send_word(word, 3);
            if (ifc.hold) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                ifc.hold = 1'b0;
            end
            wait_load(lat, w);
            chk("t6_word", w, word);
            if (k == 254) chk("t6_cnt_255", ifc.word_cnt, 255);
        end
        chk("t6_cnt_wrap", ifc.word_cnt, 0);

        // Free-running random traffic, including framing errors and short resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ifc.ser_valid = $urandom_range(0, 2) != 0;
            ifc.ser_sof   = $urandom_range(0, 4) == 0;
            ifc.ser_in    = $urandom_range(0, 1) == 1;
            ifc.hold      = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        ifc.ser_valid = 1'b0;
        ifc.hold      = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
